// File: rtl/bitcell_array.sv
// ============================================================================
// Module   : bitcell_array
// Purpose  : Word-organised flop storage array with a req/ready handshake, a
//            one-edge registered read and a post-reset clear sweep.
//            Define BITCELL_ARRAY_PARITY_EN to add per-word even parity and
//            the parity_err output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bitcell_array #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              r_w,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  in,
    output logic              ready,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid
`ifdef BITCELL_ARRAY_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam logic [1:0] c_INIT = 2'd0;
    localparam logic [1:0] c_IDLE = 2'd1;
    localparam logic [1:0] c_READ = 2'd2;

    localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(DEPTH - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_init_cnt;
    logic [ADDR_W-1:0] r_addr_q;
    logic [WIDTH-1:0]  r_out;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_addr_ok;
    logic              w_q_ok;
    logic              w_wr;
    logic [WIDTH-1:0]  w_rd_word;

    assign ready     = (r_state == c_IDLE);
    assign w_addr_ok = ({1'b0, addr} < c_DEPTH);
    assign w_q_ok    = ({1'b0, r_addr_q} < c_DEPTH);
    assign w_wr      = ready & sel & r_w & w_addr_ok;
    assign w_rd_word = w_q_ok ? r_mem[r_addr_q] : '0;

    assign out       = r_out;
    assign out_valid = r_out_valid;

    // Storage has no reset port; the INIT sweep is its only clear.
`ifdef BITCELL_ARRAY_PARITY_EN
    logic [DEPTH-1:0] r_par;
    logic             r_par_err;

    always_ff @(posedge clk) begin
        if (r_state == c_INIT) begin
            r_mem[r_init_cnt] <= '0;
            r_par[r_init_cnt] <= 1'b0;
        end else if (w_wr) begin
            r_mem[addr] <= in;
            r_par[addr] <= ^in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= (r_state == c_READ) && w_q_ok &&
                         ((^w_rd_word) != r_par[r_addr_q]);
        end
    end

    assign parity_err = r_par_err;
`else
    always_ff @(posedge clk) begin
        if (r_state == c_INIT) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_wr) begin
            r_mem[addr] <= in;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_INIT;
            r_init_cnt  <= '0;
            r_addr_q    <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (r_state == c_READ);
            r_out       <= (r_state == c_READ) ? w_rd_word : '0;
            case (r_state)
                c_INIT: begin
                    r_init_cnt <= r_init_cnt + ADDR_W'(1);
                    if (r_init_cnt == c_LAST) begin
                        r_state <= c_IDLE;
                    end
                end
                c_IDLE: begin
                    if (sel && !r_w) begin
                        r_addr_q <= addr;
                        r_state  <= c_READ;
                    end
                end
                c_READ: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state    <= c_INIT;
                    r_init_cnt <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bitcell_array.sv
// ============================================================================
// Module   : tb_bitcell_array
// Purpose  : Self-checking bench: two instances (DEPTH 16 and 12) share one
//            stimulus stream and are compared every cycle to a word-level model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bitcell_array;

    logic       clk = 1'b0;
    logic       rst, sel, r_w;
    logic [3:0] addr;
    logic [7:0] din;
    logic       rdy0, rdy1, ov0, ov1;
    logic [7:0] out0, out1;
`ifdef BITCELL_ARRAY_PARITY_EN
    logic       pe0, pe1;
    logic [15:0] par_tmp;
`endif

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;
    bit  par_skip = 1'b0;

    always #5 clk = ~clk;

    bitcell_array #(.WIDTH(8), .DEPTH(16)) dut0 (
        .clk(clk), .rst(rst), .sel(sel), .r_w(r_w), .addr(addr), .in(din),
        .ready(rdy0), .out(out0), .out_valid(ov0)
`ifdef BITCELL_ARRAY_PARITY_EN
        , .parity_err(pe0)
`endif
    );

    bitcell_array #(.WIDTH(8), .DEPTH(12)) dut1 (
        .clk(clk), .rst(rst), .sel(sel), .r_w(r_w), .addr(addr), .in(din),
        .ready(rdy1), .out(out1), .out_valid(ov1)
`ifdef BITCELL_ARRAY_PARITY_EN
        , .parity_err(pe1)
`endif
    );

    // Word-level reference: memory contents, cycles since reset, pending read.
    int         depth_m [2] = '{16, 12};
    logic [7:0] mmem [2][16];
    int         cyc  [2];
    bit         pend [2];
    int         pa   [2];
    logic [7:0] e_out [2];
    bit         e_val [2];
    bit         rdy_now;

    function automatic bit exp_rdy(input int k);
        return (cyc[k] >= depth_m[k]) && !pend[k];
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                cyc[k] = 0; pend[k] = 1'b0; pa[k] = 0;
                e_out[k] = 8'h00; e_val[k] = 1'b0;
                for (int j = 0; j < 16; j++) mmem[k][j] = 8'h00;
            end else begin
                rdy_now  = exp_rdy(k);
                e_out[k] = 8'h00;
                e_val[k] = 1'b0;
                if (pend[k]) begin
                    e_val[k] = 1'b1;
                    e_out[k] = (pa[k] < depth_m[k]) ? mmem[k][pa[k]] : 8'h00;
                    pend[k]  = 1'b0;
                end else if (rdy_now && sel) begin
                    if (r_w) begin
                        if (int'(addr) < depth_m[k]) mmem[k][addr] = din;
                    end else begin
                        pend[k] = 1'b1;
                        pa[k]   = int'(addr);
                    end
                end
                if (cyc[k] < depth_m[k]) cyc[k]++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready0",     {31'd0, rdy0}, {31'd0, exp_rdy(0)});
            chk("ready1",     {31'd0, rdy1}, {31'd0, exp_rdy(1)});
            chk("out_valid0", {31'd0, ov0},  {31'd0, e_val[0]});
            chk("out_valid1", {31'd0, ov1},  {31'd0, e_val[1]});
            chk("out0",       {24'd0, out0}, {24'd0, e_out[0]});
            chk("out1",       {24'd0, out1}, {24'd0, e_out[1]});
`ifdef BITCELL_ARRAY_PARITY_EN
            if (!par_skip) begin
                chk("parity_err0", {31'd0, pe0}, 32'd0);
                chk("parity_err1", {31'd0, pe1}, 32'd0);
            end
`endif
        end
    end

    task automatic req(input logic s, input logic w, input logic [3:0] a, input logic [7:0] d);
        sel = s; r_w = w; addr = a; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a);
        req(1'b1, 1'b0, a, 8'h00);
        req(1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        int got0 = -1;
        int got1 = -1;
        while ((got0 < 0 || got1 < 0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (rdy0 && got0 < 0) got0 = n;
            if (rdy1 && got1 < 0) got1 = n;
        end
        chk({nm, "_len16"}, got0, 32'd16);
        chk({nm, "_len12"}, got1, 32'd12);
    endtask

    initial begin
        sel = 1'b0; r_w = 1'b0; addr = 4'h0; din = 8'h00; rst = 1'b0;
        #2 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, rdy0}, 32'd0);
        chk("rst_valid", {31'd0, ov0},  32'd0);
        chk("rst_out",   {24'd0, out0}, 32'd0);
        rst = 1'b0;
        wait_ready("init");

        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            chk("clr_out",   {24'd0, out0}, 32'd0);
            chk("clr_valid", {31'd0, ov0},  32'd1);
        end

        req(1'b1, 1'b1, 4'd3, 8'hA5);
        req(1'b1, 1'b1, 4'd4, 8'h3C);
        req(1'b1, 1'b0, 4'd3, 8'h00);
        chk("rd3_notyet", {31'd0, ov0}, 32'd0);
        req(1'b0, 1'b0, 4'd0, 8'h00);
        chk("rd3_out",   {24'd0, out0}, 32'hA5);
        chk("rd3_valid", {31'd0, ov0},  32'd1);
        rd(4'd4);
        chk("rd4_out",   {24'd0, out0}, 32'h3C);
        chk("rd4_out_d12", {24'd0, out1}, 32'h3C);

        req(1'b1, 1'b1, 4'd7, 8'h5A);
        rd(4'd7);
        chk("wr_rd7", {24'd0, out0}, 32'h5A);

        req(1'b1, 1'b0, 4'd9, 8'h00);
        req(1'b1, 1'b1, 4'd9, 8'hFF);
        chk("busy_rd9_valid", {31'd0, ov0}, 32'd1);
        rd(4'd9);
        chk("busy_wr_ignored", {24'd0, out0}, 32'h00);

        req(1'b1, 1'b1, 4'd13, 8'h11);
        rd(4'd13);
        chk("oor_out12",   {24'd0, out1}, 32'h00);
        chk("oor_valid12", {31'd0, ov1},  32'd1);
        chk("inr_out16",   {24'd0, out0}, 32'h11);
        rd(4'd3);
        chk("oor_keep3", {24'd0, out1}, 32'hA5);

`ifdef BITCELL_ARRAY_PARITY_EN
        req(1'b1, 1'b1, 4'd5, 8'h05);
        par_skip = 1'b1;
        par_tmp = dut0.r_par;
        par_tmp[5] = ~par_tmp[5];
        force dut0.r_par = par_tmp;
        rd(4'd5);
        chk("parity_err_forced", {31'd0, pe0}, 32'd1);
        release dut0.r_par;
        req(1'b1, 1'b1, 4'd5, 8'h05);
        par_skip = 1'b0;
`endif

        for (int i = 0; i < 3000; i++) begin
            req(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 8'($urandom));
        end
        req(1'b0, 1'b0, 4'd0, 8'h00);

        req(1'b1, 1'b1, 4'd3, 8'hA5);
        req(1'b1, 1'b0, 4'd3, 8'h00);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, ov0},  32'd0);
        chk("rst_mid_ready", {31'd0, rdy0}, 32'd0);
        chk("rst_mid_out",   {24'd0, out0}, 32'd0);
        sel = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_abort_valid", {31'd0, ov0}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ready("reinit");
        rd(4'd3);
        chk("reinit_rd3", {24'd0, out0}, 32'h00);
        chk("reinit_valid", {31'd0, ov0}, 32'd1);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
